// File: rtl/rf_pkg.sv
// Shared types, constants and index-validity helper for the rf_sb register file.
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int N_REGS_MAX = 32;
  localparam int ID_W       = 5;

  typedef logic [ID_W-1:0] reg_id_t;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_e;

  // x0 is hardwired to zero, and indices at or above n_regs do not exist.
  function automatic logic id_valid(input int unsigned id, input int unsigned n_regs);
    return (id != 0) && (id < n_regs);
  endfunction

endpackage

// File: rtl/rf_sb_if.sv
// Issue/writeback bundle of the rf_sb register file: reads, claims, writeback, flush, bulk clear.
interface rf_sb_if #(
  parameter int XLEN = 32,
  parameter int ID_W = 5,
  parameter int N_RD = 2
);
  // Writeback handshake: a write transfers on the rising edge where wen and wready are
  // both high; while wen is high and wready low, upstream holds rd/wdata unchanged.
  logic                 wen;
  logic [ID_W-1:0]      rd;
  logic [XLEN-1:0]      wdata;
  logic                 wready;
  logic [N_RD*ID_W-1:0] rs;
  logic [N_RD*XLEN-1:0] rdata;
  logic [N_RD-1:0]      rstall;
  logic                 claim_valid;
  logic [ID_W-1:0]      claim_rd;
  logic                 flush;
  logic                 clear_req;
  logic                 clear_busy;
  logic                 clear_done;

  modport master (
    output wen, rd, wdata, rs, claim_valid, claim_rd, flush, clear_req,
    input  wready, rdata, rstall, clear_busy, clear_done
  );

  modport slave (
    input  wen, rd, wdata, rs, claim_valid, claim_rd, flush, clear_req,
    output wready, rdata, rstall, clear_busy, clear_done
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Pending-writeback scoreboard: one busy bit per register and per-read-port stall generation.
module rf_scoreboard #(
  parameter int N_REGS = 32,
  parameter int N_RD   = 2,
  parameter int ID_W   = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 claim_en,
  input  logic [ID_W-1:0]      claim_rd,
  input  logic                 wr_en,
  input  logic [ID_W-1:0]      wr_rd,
  input  logic                 clr_all,
  input  logic                 hold,
  input  logic [N_RD*ID_W-1:0] rs,
  output logic [N_RD-1:0]      rstall
);

  logic [N_REGS-1:0] busy;

  // Priority: clear-all, then a new claim, then the retiring write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int i = 1; i < N_REGS; i++) begin
        if (clr_all)
          busy[i] <= 1'b0;
        else if (claim_en && (claim_rd == ID_W'(i)))
          busy[i] <= 1'b1;
        else if (wr_en && (wr_rd == ID_W'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    logic [ID_W-1:0] idx;
    logic            hit;
    rstall = '0;
    idx    = '0;
    hit    = 1'b0;
    for (int k = 0; k < N_RD; k++) begin
      idx = rs[k*ID_W +: ID_W];
      hit = 1'b0;
      for (int i = 1; i < N_REGS; i++) begin
        if (idx == ID_W'(i)) hit = busy[i];
      end
      // A same-cycle writeback to the source is forwarded, so it satisfies the stall.
      rstall[k] = hit && !hold && !(wr_en && (wr_rd == idx));
    end
  end

endmodule

// File: rtl/rf_sb.sv
// Parametrised integer register file with write-first bypass, scoreboard and bulk-clear engine.
// Optional per-register even parity with sticky par_err when RF_PARITY_EN is defined.
module rf_sb #(
  parameter int XLEN   = rf_pkg::XLEN,
  parameter int N_REGS = 32,
  parameter int N_RD   = 2,
  parameter int ID_W   = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  rf_sb_if.slave             bus,
  output rf_pkg::clr_state_e clr_state
`ifdef RF_PARITY_EN
  ,
  output logic               par_err
`endif
);

  import rf_pkg::*;

  clr_state_e      state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt;
  logic            done_q, done_nxt;
  logic            sweep, last, start;
  logic            wready_v, wr_acc, claim_en, clr_all;
  logic [XLEN-1:0] regs [1:N_REGS-1];
  logic [N_RD*XLEN-1:0] rdata_v;

  assign sweep = (state == CLR_SWEEP);
  assign last  = sweep && (ptr == ID_W'(N_REGS-1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= CLR_IDLE;
      ptr    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    start     = 1'b0;
    wready_v  = 1'b1;
    case (state)
      CLR_IDLE: begin
        if (bus.clear_req) begin
          start     = 1'b1;
          state_nxt = CLR_SWEEP;
          ptr_nxt   = ID_W'(1);
        end
      end
      CLR_SWEEP: begin
        wready_v = 1'b0;
        // ptr parks on the last register instead of wrapping.
        if (ptr == ID_W'(N_REGS-1)) begin
          state_nxt = CLR_IDLE;
          done_nxt  = 1'b1;
        end else begin
          ptr_nxt = ptr + ID_W'(1);
        end
      end
      default: begin
        state_nxt = CLR_IDLE;
      end
    endcase
  end

  assign wr_acc   = bus.wen && wready_v && id_valid(32'(bus.rd), N_REGS);
  assign claim_en = bus.claim_valid && !sweep && id_valid(32'(bus.claim_rd), N_REGS);
  assign clr_all  = bus.flush || start;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < N_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < N_REGS; i++) begin
        if (sweep && (ptr == ID_W'(i)))
          regs[i] <= '0;
        else if (wr_acc && (bus.rd == ID_W'(i)))
          regs[i] <= bus.wdata;
      end
    end
  end

`ifdef RF_PARITY_EN
  logic par_bits [1:N_REGS-1];
  logic par_mism;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < N_REGS; i++) par_bits[i] <= 1'b0;
      par_err <= 1'b0;
    end else begin
      for (int i = 1; i < N_REGS; i++) begin
        if (sweep && (ptr == ID_W'(i)))
          par_bits[i] <= 1'b0;
        else if (wr_acc && (bus.rd == ID_W'(i)))
          par_bits[i] <= ^bus.wdata;
      end
      par_err <= last ? 1'b0 : (par_err | par_mism);
    end
  end
`endif

  always_comb begin
    logic [ID_W-1:0] idx;
    logic [XLEN-1:0] stored;
    logic            byp;
`ifdef RF_PARITY_EN
    logic            stored_par;
    par_mism   = 1'b0;
    stored_par = 1'b0;
`endif
    rdata_v = '0;
    idx     = '0;
    stored  = '0;
    byp     = 1'b0;
    for (int k = 0; k < N_RD; k++) begin
      idx    = bus.rs[k*ID_W +: ID_W];
      stored = '0;
`ifdef RF_PARITY_EN
      stored_par = 1'b0;
`endif
      for (int i = 1; i < N_REGS; i++) begin
        if (idx == ID_W'(i)) begin
          stored = regs[i];
`ifdef RF_PARITY_EN
          stored_par = par_bits[i];
`endif
        end
      end
      // wr_acc implies rd is valid, so a match also implies idx is valid.
      byp = wr_acc && (bus.rd == idx);
      rdata_v[k*XLEN +: XLEN] = byp ? bus.wdata : stored;
`ifdef RF_PARITY_EN
      if (!byp && ((^stored) != stored_par)) par_mism = 1'b1;
`endif
    end
  end

  rf_scoreboard #(
    .N_REGS (N_REGS),
    .N_RD   (N_RD),
    .ID_W   (ID_W)
  ) u_sb (
    .clock    (clock),
    .reset_n  (reset_n),
    .claim_en (claim_en),
    .claim_rd (bus.claim_rd),
    .wr_en    (wr_acc),
    .wr_rd    (bus.rd),
    .clr_all  (clr_all),
    .hold     (sweep),
    .rs       (bus.rs),
    .rstall   (bus.rstall)
  );

  assign bus.rdata      = rdata_v;
  assign bus.wready     = wready_v;
  assign bus.clear_busy = sweep;
  assign bus.clear_done = done_q;
  assign clr_state      = state;

endmodule

// File: tb/tb_rf_sb.sv
// Directed bench for rf_sb: a 32-register instance and a 16-register (RV32E) instance.
module tb_rf_sb;
  import rf_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  rf_sb_if #(.XLEN(32), .ID_W(5), .N_RD(2)) bus ();
  rf_sb_if #(.XLEN(32), .ID_W(5), .N_RD(2)) bus16 ();
  clr_state_e st32, st16;
`ifdef RF_PARITY_EN
  logic pe32, pe16;
`endif

  rf_sb #(.XLEN(32), .N_REGS(32), .N_RD(2), .ID_W(5)) dut (
    .clock (clock), .reset_n (reset_n), .bus (bus), .clr_state (st32)
`ifdef RF_PARITY_EN
    , .par_err (pe32)
`endif
  );

  rf_sb #(.XLEN(32), .N_REGS(16), .N_RD(2), .ID_W(5)) dut16 (
    .clock (clock), .reset_n (reset_n), .bus (bus16), .clr_state (st16)
`ifdef RF_PARITY_EN
    , .par_err (pe16)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int busy_cnt, done_cnt;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle_all();
    bus.wen = 1'b0; bus.rd = '0; bus.wdata = '0; bus.rs = '0;
    bus.claim_valid = 1'b0; bus.claim_rd = '0; bus.flush = 1'b0; bus.clear_req = 1'b0;
    bus16.wen = 1'b0; bus16.rd = '0; bus16.wdata = '0; bus16.rs = '0;
    bus16.claim_valid = 1'b0; bus16.claim_rd = '0; bus16.flush = 1'b0; bus16.clear_req = 1'b0;
  endtask

  task automatic rd_ports(input logic [4:0] a, input logic [4:0] b);
    bus.rs = {b, a};
  endtask

  task automatic rd16_ports(input logic [4:0] a, input logic [4:0] b);
    bus16.rs = {b, a};
  endtask

  initial begin
    reset_n = 1'b0;
    idle_all();
    rd_ports(5'd5, 5'd7);
    #2;
    check("rst_wready", 64'(bus.wready), 64'd1);
    check("rst_clear_busy", 64'(bus.clear_busy), 64'd0);
    check("rst_clear_done", 64'(bus.clear_done), 64'd0);
    check("rst_rstall", 64'(bus.rstall), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_state", 64'(st32), 64'(CLR_IDLE));
    @(negedge clock); reset_n = 1'b1;

    // Write-first bypass and x0 hardwiring
    @(negedge clock); bus.wen = 1'b1; bus.rd = 5'd5; bus.wdata = 32'hDEADBEEF; rd_ports(5'd5, 5'd0);
    #1 check("t1_bypass", 64'(bus.rdata[31:0]), 64'hDEADBEEF);
    @(negedge clock); bus.wen = 1'b0;
    #1 check("t1_stored", 64'(bus.rdata[31:0]), 64'hDEADBEEF);
    @(negedge clock); bus.wen = 1'b1; bus.rd = 5'd0; bus.wdata = 32'h1234; rd_ports(5'd0, 5'd0);
    #1 check("t1_x0_bypass", 64'(bus.rdata[31:0]), 64'd0);
    @(negedge clock); bus.wen = 1'b0;
    #1 check("t1_x0_stored", 64'(bus.rdata[31:0]), 64'd0);

    // Claim then writeback satisfies the stall
    @(negedge clock); bus.claim_valid = 1'b1; bus.claim_rd = 5'd7; rd_ports(5'd0, 5'd7);
    #1 check("t2_pre_claim", 64'(bus.rstall), 64'd0);
    @(negedge clock); bus.claim_valid = 1'b0;
    #1 check("t2_stall", 64'(bus.rstall), 64'b10);
    @(negedge clock); bus.wen = 1'b1; bus.rd = 5'd7; bus.wdata = 32'h55;
    #1 check("t2_wb_stall", 64'(bus.rstall), 64'd0);
    check("t2_wb_bypass", 64'(bus.rdata[63:32]), 64'h55);
    @(negedge clock); bus.wen = 1'b0;
    #1 check("t2_after_stall", 64'(bus.rstall), 64'd0);
    check("t2_after_data", 64'(bus.rdata[63:32]), 64'h55);

    // Same-cycle claim and write: claim wins; flush drops it
    @(negedge clock); bus.claim_valid = 1'b1; bus.claim_rd = 5'd3;
    bus.wen = 1'b1; bus.rd = 5'd3; bus.wdata = 32'h9; rd_ports(5'd3, 5'd3);
    #1 check("t3_bypass", 64'(bus.rdata[31:0]), 64'h9);
    @(negedge clock); bus.claim_valid = 1'b0; bus.wen = 1'b0;
    #1 check("t3_busy_set", 64'(bus.rstall), 64'b11);
    check("t3_data", 64'(bus.rdata[31:0]), 64'h9);
    @(negedge clock); bus.flush = 1'b1;
    #1 check("t3_flush_same_cycle", 64'(bus.rstall), 64'b11);
    @(negedge clock); bus.flush = 1'b0;
    #1 check("t3_flushed", 64'(bus.rstall), 64'd0);
    @(negedge clock); bus.flush = 1'b1; bus.claim_valid = 1'b1; bus.claim_rd = 5'd3;
    @(negedge clock); bus.flush = 1'b0; bus.claim_valid = 1'b0;
    #1 check("t3_flush_beats_claim", 64'(bus.rstall), 64'd0);

    // Fill, read back, then bulk clear
    for (int i = 1; i < 32; i++) begin
      @(negedge clock); bus.wen = 1'b1; bus.rd = 5'(i); bus.wdata = 32'h1000_0000 + 32'(i) * 32'h0101;
      exp_q.push_back(32'h1000_0000 + 32'(i) * 32'h0101);
    end
    @(negedge clock); bus.wen = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rd_ports(5'(i), 5'd0);
      #1 check("t4_fill", 64'(bus.rdata[31:0]), 64'(exp_q.pop_front()));
    end
    @(negedge clock); bus.clear_req = 1'b1; rd_ports(5'd0, 5'd0);
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      bus.clear_req = (c == 5);
      bus.wen = (c == 4); bus.rd = 5'd2; bus.wdata = 32'hFFFF_FFFF;
      bus.claim_valid = (c == 4); bus.claim_rd = 5'd9;
      if (c == 4) rd_ports(5'd2, 5'd9);
      if (c == 10) rd_ports(5'd1, 5'd31);
      #1;
      if (bus.clear_busy) busy_cnt++;
      if (bus.clear_done) done_cnt++;
      if (c == 4) begin
        check("t4_wready_sweep", 64'(bus.wready), 64'd0);
        check("t4_stall_sweep", 64'(bus.rstall), 64'd0);
        check("t4_no_bypass_sweep", 64'(bus.rdata[31:0]), 64'd0);
      end
      if (c == 10) begin
        check("t4_mid_zeroed", 64'(bus.rdata[31:0]), 64'd0);
        check("t4_mid_old", 64'(bus.rdata[63:32]), 64'h1000_1F1F);
        check("t4_mid_state", 64'(st32), 64'(CLR_SWEEP));
      end
      if (c == 31) check("t4_done_cycle", 64'(bus.clear_done), 64'd1);
    end
    check("t4_busy_cycles", 64'(busy_cnt), 64'd31);
    check("t4_done_pulses", 64'(done_cnt), 64'd1);
    check("t4_wready_after", 64'(bus.wready), 64'd1);
    for (int i = 1; i < 32; i++) begin
      rd_ports(5'(i), 5'd0);
      #1 check("t4_cleared", 64'(bus.rdata[31:0]), 64'd0);
    end
    rd_ports(5'd9, 5'd2);
    #1 check("t4_claim_ignored", 64'(bus.rstall), 64'd0);

    // Reset mid-sweep aborts the clear
    @(negedge clock); bus.wen = 1'b1; bus.rd = 5'd5; bus.wdata = 32'h77;
    @(negedge clock); bus.rd = 5'd31; bus.wdata = 32'h31;
    @(negedge clock); bus.wen = 1'b0; bus.clear_req = 1'b1; rd_ports(5'd5, 5'd31);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock); bus.clear_req = 1'b0;
    end
    #1 check("t5_mid_x31", 64'(bus.rdata[63:32]), 64'h31);
    @(negedge clock); reset_n = 1'b0;
    #1 check("t5_busy", 64'(bus.clear_busy), 64'd0);
    check("t5_state", 64'(st32), 64'(CLR_IDLE));
    check("t5_wready", 64'(bus.wready), 64'd1);
    check("t5_regs", 64'(bus.rdata), 64'd0);
    @(negedge clock); reset_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock); #1;
      if (bus.clear_done || bus.clear_busy) done_cnt++;
    end
    check("t5_no_done", 64'(done_cnt), 64'd0);

    // RV32E instance: out-of-range index ignored
    @(negedge clock); bus16.wen = 1'b1; bus16.rd = 5'd20; bus16.wdata = 32'hAAAA;
    bus16.claim_valid = 1'b1; bus16.claim_rd = 5'd20; rd16_ports(5'd20, 5'd4);
    #1 check("t6_x20_bypass", 64'(bus16.rdata[31:0]), 64'd0);
    @(negedge clock); bus16.wen = 1'b0; bus16.claim_valid = 1'b0;
    #1 check("t6_x20_data", 64'(bus16.rdata), 64'd0);
    check("t6_x20_stall", 64'(bus16.rstall), 64'd0);
    @(negedge clock); bus16.wen = 1'b1; bus16.rd = 5'd15; bus16.wdata = 32'hF;
    bus16.claim_valid = 1'b1; bus16.claim_rd = 5'd15; rd16_ports(5'd15, 5'd16);
    @(negedge clock); bus16.wen = 1'b0; bus16.claim_valid = 1'b0;
    #1 check("t6_x15_data", 64'(bus16.rdata[31:0]), 64'hF);
    check("t6_x16_data", 64'(bus16.rdata[63:32]), 64'd0);
    check("t6_x15_stall", 64'(bus16.rstall), 64'b01);
    @(negedge clock); bus16.clear_req = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock); bus16.clear_req = 1'b0; #1;
      if (bus16.clear_busy) busy_cnt++;
      if (bus16.clear_done) done_cnt++;
    end
    check("t6_busy_cycles", 64'(busy_cnt), 64'd15);
    check("t6_done_pulses", 64'(done_cnt), 64'd1);
    check("t6_x15_cleared", 64'(bus16.rdata[31:0]), 64'd0);
    check("t6_stall_cleared", 64'(bus16.rstall), 64'd0);

`ifdef RF_PARITY_EN
    @(negedge clock); bus16.wen = 1'b1; bus16.rd = 5'd4; bus16.wdata = 32'h3; rd16_ports(5'd4, 5'd0);
    @(negedge clock); bus16.wen = 1'b0;
    @(negedge clock); #1 check("t6_par_clean", 64'(pe16), 64'd0);
    dut16.regs[4] = dut16.regs[4] ^ 32'h1;
    @(negedge clock); #1 check("t6_par_set", 64'(pe16), 64'd1);
    rd16_ports(5'd0, 5'd0);
    repeat (3) @(negedge clock);
    #1 check("t6_par_sticky", 64'(pe16), 64'd1);
    reset_n = 1'b0;
    #1 check("t6_par_reset", 64'(pe16), 64'd0);
    @(negedge clock); reset_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
